// File: rtl/gtxe2_chnl_rx_gearbox.sv
// gtxe2_chnl_rx_gearbox: packs internal words into interface words behind a FWFT FIFO.
// Optional macro GTXE2_RX_GEARBOX_COMMA_ALIGN_EN realigns on K28.5 in the low byte.
module gtxe2_chnl_rx_gearbox #(
   parameter int internal_data_width  = 16,
   parameter int interface_data_width = 32,
   parameter int internal_isk_width   = 2,
   parameter int interface_isk_width  = 4,
   parameter int log_depth            = 3
) (
   input  logic                            usrclk2,
   input  logic                            reset,
   input  logic [internal_data_width-1:0]  indata,
   input  logic [internal_isk_width-1:0]   inisk,
   input  logic                            inval,
   input  logic                            realign,
   output logic [interface_data_width-1:0] outdata,
   output logic [interface_isk_width-1:0]  outisk,
   output logic                            outval,
   input  logic                            outready,
   output logic [log_depth:0]              level,
   output logic                            overflow
);

   localparam int DIV   = interface_data_width / internal_data_width;
   localparam int LANES = (DIV > 1) ? DIV - 1 : 1;
   localparam int DEPTH = 1 << log_depth;
   localparam int IW    = internal_data_width;
   localparam int KW    = internal_isk_width;

   localparam logic [1:0] LAST    = 2'(DIV - 1);
   localparam logic [1:0] RESTART = (DIV == 1) ? 2'd0 : 2'd1;
   localparam logic [log_depth:0] PTR_ONE = 1;

   logic [1:0]    wordcounter;
   logic [1:0]    lane_sel;
   logic [IW-1:0] lane_d [LANES];
   logic [KW-1:0] lane_k [LANES];

   logic [interface_data_width-1:0] mem_d [DEPTH];
   logic [interface_isk_width-1:0]  mem_k [DEPTH];
   logic [log_depth:0]              wr_ptr;
   logic [log_depth:0]              rd_ptr;

   logic [interface_data_width-1:0] asm_d;
   logic [interface_isk_width-1:0]  asm_k;

   logic comma;
   logic align;
   logic push;
   logic pop;
   logic full;
   logic accept;

`ifdef GTXE2_RX_GEARBOX_COMMA_ALIGN_EN
   assign comma = inval & inisk[0] & (indata[7:0] == 8'hBC);
`else
   assign comma = 1'b0;
`endif

   assign align    = realign | comma;
   assign lane_sel = align ? 2'd0 : wordcounter;

   // A realigned word only completes an output word when one lane is all there is.
   assign push = inval & (align ? (LAST == 2'd0) : (wordcounter == LAST));

   always_comb begin
      asm_d = '0;
      asm_k = '0;
      for (int i = 0; i < DIV - 1; i++) begin
         asm_d[i*IW +: IW] = lane_d[i];
         asm_k[i*KW +: KW] = lane_k[i];
      end
      asm_d[(DIV-1)*IW +: IW] = indata;
      asm_k[(DIV-1)*KW +: KW] = inisk;
   end

   always_ff @(posedge usrclk2 or negedge reset) begin
      if (!reset) begin
         wordcounter <= 2'd0;
         for (int i = 0; i < LANES; i++) begin
            lane_d[i] <= '0;
            lane_k[i] <= '0;
         end
      end else begin
         if (inval) begin
            if (align)
               wordcounter <= RESTART;
            else if (wordcounter == LAST)
               wordcounter <= 2'd0;
            else
               wordcounter <= wordcounter + 2'd1;
         end else if (align) begin
            wordcounter <= 2'd0;
         end
         for (int i = 0; i < LANES; i++) begin
            if (inval && (lane_sel == 2'(i))) begin
               lane_d[i] <= indata;
               lane_k[i] <= inisk;
            end
         end
      end
   end

   // Full: same slot, opposite lap.
   assign full = (wr_ptr[log_depth] != rd_ptr[log_depth]) &&
                 (wr_ptr[log_depth-1:0] == rd_ptr[log_depth-1:0]);

   assign outval  = (wr_ptr != rd_ptr);
   assign pop     = outval & outready;
   assign accept  = push & (~full | pop);
   assign level   = wr_ptr - rd_ptr;
   assign outdata = mem_d[rd_ptr[log_depth-1:0]];
   assign outisk  = mem_k[rd_ptr[log_depth-1:0]];

   always_ff @(posedge usrclk2 or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] <= '0;
            mem_k[i] <= '0;
         end
      end else begin
         if (accept) begin
            mem_d[wr_ptr[log_depth-1:0]] <= asm_d;
            mem_k[wr_ptr[log_depth-1:0]] <= asm_k;
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !accept)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gtxe2_chnl_rx_gearbox.sv
// tb_gtxe2_chnl_rx_gearbox: drives a div=2 and a div=4 gearbox with shared stimulus
// and compares both against a queue-based model plus directed vectors.
module tb_gtxe2_chnl_rx_gearbox;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] indata;
   logic [1:0]  inisk;
   logic        inval;
   logic        realign;
   logic        outready;

   logic [31:0] d2;
   logic [3:0]  k2;
   logic        v2;
   logic [3:0]  l2;
   logic        o2;
   logic [63:0] d4;
   logic [7:0]  k4;
   logic        v4;
   logic [3:0]  l4;
   logic        o4;

   gtxe2_chnl_rx_gearbox #(
      .internal_data_width (16),
      .interface_data_width(32),
      .internal_isk_width  (2),
      .interface_isk_width (4),
      .log_depth           (3)
   ) u_div2 (
      .usrclk2 (clk),
      .reset   (rst_n),
      .indata  (indata),
      .inisk   (inisk),
      .inval   (inval),
      .realign (realign),
      .outdata (d2),
      .outisk  (k2),
      .outval  (v2),
      .outready(outready),
      .level   (l2),
      .overflow(o2)
   );

   gtxe2_chnl_rx_gearbox #(
      .internal_data_width (16),
      .interface_data_width(64),
      .internal_isk_width  (2),
      .interface_isk_width (8),
      .log_depth           (3)
   ) u_div4 (
      .usrclk2 (clk),
      .reset   (rst_n),
      .indata  (indata),
      .inisk   (inisk),
      .inval   (inval),
      .realign (realign),
      .outdata (d4),
      .outisk  (k4),
      .outval  (v4),
      .outready(outready),
      .level   (l4),
      .overflow(o4)
   );

   int checks = 0;
   int errors = 0;

   // Model: pending input words and FIFO contents, per DUT (0: div2, 1: div4).
   logic [15:0] pd [2][$];
   logic [1:0]  pk [2][$];
   logic [63:0] fd [2][$];
   logic [7:0]  fk [2][$];
   bit          ovf [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         pd[d].delete();
         pk[d].delete();
         fd[d].delete();
         fk[d].delete();
         ovf[d] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit          re;
      bit          full;
      bit          popped;
      int          div;
      logic [63:0] ad;
      logic [7:0]  ak;
      re = realign;
`ifdef GTXE2_RX_GEARBOX_COMMA_ALIGN_EN
      if (inval && inisk[0] && indata[7:0] == 8'hBC) re = 1'b1;
`endif
      for (int d = 0; d < 2; d++) begin
         div    = (d == 0) ? 2 : 4;
         full   = (fd[d].size() == 8);
         popped = outready && (fd[d].size() > 0);
         if (popped) begin
            fd[d].delete(0);
            fk[d].delete(0);
         end
         if (re) begin
            pd[d].delete();
            pk[d].delete();
         end
         if (inval) begin
            pd[d].push_back(indata);
            pk[d].push_back(inisk);
         end
         if (pd[d].size() == div) begin
            ad = '0;
            ak = '0;
            for (int i = 0; i < div; i++) begin
               ad = ad | (64'(pd[d][i]) << (16 * i));
               ak = ak | (8'(pk[d][i]) << (2 * i));
            end
            pd[d].delete();
            pk[d].delete();
            if (!full || popped) begin
               fd[d].push_back(ad);
               fk[d].push_back(ak);
            end else begin
               ovf[d] = 1'b1;
            end
         end
      end
   endtask

   task automatic model_check();
      logic        av;
      logic [63:0] ad;
      logic [7:0]  ak;
      logic [3:0]  al;
      logic        ao;
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            av = v2; ad = 64'(d2); ak = 8'(k2); al = l2; ao = o2;
         end else begin
            av = v4; ad = d4; ak = k4; al = l4; ao = o4;
         end
         chk($sformatf("model%0d_outval", d), 64'(av), 64'(fd[d].size() != 0));
         chk($sformatf("model%0d_level", d), 64'(al), 64'(fd[d].size()));
         chk($sformatf("model%0d_overflow", d), 64'(ao), 64'(ovf[d]));
         if (fd[d].size() > 0) begin
            chk($sformatf("model%0d_outdata", d), ad, fd[d][0]);
            chk($sformatf("model%0d_outisk", d), 64'(ak), 64'(fk[d][0]));
         end
      end
   endtask

   task automatic cyc(input logic v, input logic r, input logic [15:0] dt,
                      input logic [1:0] k, input logic rdy);
      inval    = v;
      realign  = r;
      indata   = dt;
      inisk    = k;
      outready = rdy;
      @(posedge clk);
      model_step();
      #1;
      model_check();
   endtask

   typedef struct packed {
      logic        v;
      logic        r;
      logic [15:0] d;
      logic [1:0]  k;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic [3:0]  el;
   } vec_t;

   vec_t tbl [9];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 16'h1111, 2'b01, 1'b1, 1'b0, 32'h0, 4'h0, 4'd0};
      tbl[1] = '{1'b1, 1'b0, 16'h2222, 2'b00, 1'b1, 1'b1, 32'h2222_1111, 4'b0001, 4'd1};
      tbl[2] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 32'h0, 4'h0, 4'd0};
      tbl[3] = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b1, 1'b0, 32'h0, 4'h0, 4'd0};
      tbl[4] = '{1'b1, 1'b0, 16'h3333, 2'b00, 1'b1, 1'b0, 32'h0, 4'h0, 4'd0};
      tbl[5] = '{1'b1, 1'b1, 16'h4444, 2'b10, 1'b1, 1'b0, 32'h0, 4'h0, 4'd0};
      tbl[6] = '{1'b1, 1'b0, 16'h5555, 2'b00, 1'b1, 1'b1, 32'h5555_4444, 4'b0010, 4'd1};
      tbl[7] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 32'h5555_4444, 4'b0010, 4'd1};
      tbl[8] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 32'h0, 4'h0, 4'd0};

      model_reset();
      rst_n    = 1'b1;
      inval    = 1'b0;
      realign  = 1'b0;
      indata   = '0;
      inisk    = '0;
      outready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_outval2", 64'(v2), 64'(0));
      chk("reset_outdata2", 64'(d2), 64'(0));
      chk("reset_outisk2", 64'(k2), 64'(0));
      chk("reset_level2", 64'(l2), 64'(0));
      chk("reset_overflow2", 64'(o2), 64'(0));
      chk("reset_outval4", 64'(v4), 64'(0));
      chk("reset_outdata4", d4, 64'(0));
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Directed table on the div=2 instance.
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].k, tbl[i].rdy);
         chk($sformatf("tbl%0d_outval", i), 64'(v2), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d_level", i), 64'(l2), 64'(tbl[i].el));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_outdata", i), 64'(d2), 64'(tbl[i].ed));
            chk($sformatf("tbl%0d_outisk", i), 64'(k2), 64'(tbl[i].ek));
         end
      end

      // div=4 realign abandons three buffered words.
      cyc(1'b0, 1'b1, 16'h0, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'h0101, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'h0202, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'h0303, 2'b00, 1'b1);
      cyc(1'b1, 1'b1, 16'hAAAA, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'hBBBB, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'hCCCC, 2'b00, 1'b1);
      chk("div4_no_early", 64'(v4), 64'(0));
      cyc(1'b1, 1'b0, 16'hDDDD, 2'b00, 1'b1);
      chk("div4_outval", 64'(v4), 64'(1));
      chk("div4_outdata", d4, 64'hDDDD_CCCC_BBBB_AAAA);
      cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
      chk("div4_single", 64'(v4), 64'(0));

      // Overflow: 18 words, no consumer.
      cyc(1'b0, 1'b1, 16'h0, 2'b00, 1'b1);
      for (int i = 0; i < 18; i++)
         cyc(1'b1, 1'b0, 16'h1000 + 16'(i), 2'(i), 1'b0);
      chk("ovf_level", 64'(l2), 64'(8));
      chk("ovf_flag", 64'(o2), 64'(1));
      chk("ovf_head", 64'(d2), 64'h1001_1000);
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("drain%0d", j), 64'(d2),
             64'({16'h1000 + 16'(2 * j + 1), 16'h1000 + 16'(2 * j)}));
         cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
      end
      chk("drain_empty", 64'(v2), 64'(0));
      chk("ovf_sticky", 64'(o2), 64'(1));

      // Async reset mid-packing with level 3.
      cyc(1'b0, 1'b1, 16'h0, 2'b00, 1'b0);
      for (int i = 0; i < 7; i++)
         cyc(1'b1, 1'b0, 16'h3000 + 16'(i), 2'b11, 1'b0);
      chk("pre_rst_level", 64'(l2), 64'(3));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_outval", 64'(v2), 64'(0));
      chk("arst_outdata", 64'(d2), 64'(0));
      chk("arst_outisk", 64'(k2), 64'(0));
      chk("arst_level", 64'(l2), 64'(0));
      chk("arst_overflow", 64'(o2), 64'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      cyc(1'b1, 1'b0, 16'h4001, 2'b01, 1'b1);
      cyc(1'b1, 1'b0, 16'h4002, 2'b00, 1'b1);
      chk("post_rst_outdata", 64'(d2), 64'h4002_4001);
      chk("post_rst_outisk", 64'(k2), 64'(4'b0001));
      cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);

      // Push and pop together while full.
      for (int i = 0; i < 16; i++)
         cyc(1'b1, 1'b0, 16'h1000 + 16'(i), 2'b00, 1'b0);
      chk("full_level", 64'(l2), 64'(8));
      chk("full_noovf", 64'(o2), 64'(0));
      cyc(1'b1, 1'b0, 16'h2000, 2'b00, 1'b0);
      cyc(1'b1, 1'b0, 16'h2001, 2'b00, 1'b1);
      chk("pp_level", 64'(l2), 64'(8));
      chk("pp_noovf", 64'(o2), 64'(0));
      chk("pp_head", 64'(d2), 64'h1003_1002);
      for (int j = 0; j < 7; j++)
         cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
      chk("pp_tail", 64'(d2), 64'h2001_2000);
      cyc(1'b0, 1'b0, 16'h0, 2'b00, 1'b1);
      chk("pp_empty", 64'(v2), 64'(0));

      // K28.5 handling.
      cyc(1'b0, 1'b1, 16'h0, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'h0001, 2'b00, 1'b1);
      cyc(1'b1, 1'b0, 16'h00BC, 2'b01, 1'b1);
`ifdef GTXE2_RX_GEARBOX_COMMA_ALIGN_EN
      chk("comma_nopush", 64'(v2), 64'(0));
      cyc(1'b1, 1'b0, 16'h0002, 2'b00, 1'b1);
      chk("comma_outval", 64'(v2), 64'(1));
      chk("comma_outdata", 64'(d2), 64'h0002_00BC);
      chk("comma_outisk", 64'(k2), 64'(4'b0001));
`else
      chk("nocomma_outval", 64'(v2), 64'(1));
      chk("nocomma_outdata", 64'(d2), 64'h00BC_0001);
      chk("nocomma_outisk", 64'(k2), 64'(4'b0100));
      cyc(1'b1, 1'b0, 16'h0002, 2'b00, 1'b1);
`endif

      // Randomized traffic with bursts of backpressure.
      for (int c = 0; c < 600; c++) begin
         logic        v;
         logic        r;
         logic [15:0] dt;
         logic [1:0]  k;
         logic        rdy;
         v  = ($urandom_range(0, 9) < 7);
         r  = ($urandom_range(0, 19) == 0);
         dt = 16'($urandom);
         k  = 2'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            dt[7:0] = 8'hBC;
            k[0]    = 1'b1;
         end
         if ((c % 150) < 60)
            rdy = ($urandom_range(0, 9) < 2);
         else
            rdy = ($urandom_range(0, 9) < 8);
         cyc(v, r, dt, k, rdy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
